// File: rtl/output_interface_if.sv
// Display bus for output_interface: load-side capture inputs plus the
// multiplexed 7-segment drive and the frame/update pulses.
interface output_interface_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_tick;
  logic        upd_ack;

  modport master (
    output load, value, dp, digit_en, blink,
    input  an, seg, dp_n, frame_tick, upd_ack
  );

  modport slave (
    input  load, value, dp, digit_en, blink,
    output an, seg, dp_n, frame_tick, upd_ack
  );
endinterface

// File: rtl/output_interface.sv
// Four-digit multiplexed 7-segment driver. New display data is double
// buffered and only swapped in at a frame boundary so a scan never shows
// a mix of old and new digits. Each slot starts with a short blanking
// guard to hide anode/segment switching ghosting.
module output_interface #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 8,
  parameter int BLINK_FRAMES = 125
) (
  input  logic               clk,
  input  logic               reset,
  output_interface_if.slave  bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_TC   = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_GRD  = DW'(GUARD);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_FRAMES - 1);

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [BW-1:0] bcnt;
  logic          blink_phase;

  logic [15:0]   pend_value;
  logic [3:0]    pend_dp, pend_en, pend_blink;
  logic          pend_valid;

  logic [15:0]   act_value;
  logic [3:0]    act_dp, act_en, act_blink;

  logic          div_tc;
  logic          frame_end;
  logic          blank_now;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  // Active-low hex decode, segment order g..a; lowercase b and d.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  // Slot timing, blanking decision and segment decode for the current digit.
  always_comb begin
    div_tc    = (div == DIV_TC);
    frame_end = div_tc && (idx == 2'd3);
    nibble    = act_value[{idx, 2'b00} +: 4];
    seg_dec   = hex_decode(nibble);
    blank_now = !act_en[idx] || (act_blink[idx] && blink_phase) || (div < DIV_GRD);
  end

  // Scan divider, digit index and blink phase; the blink counter counts frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div         <= '0;
      idx         <= 2'd0;
      bcnt        <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (div_tc) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
      if (frame_end) begin
        if (bcnt == BLINK_TC) begin
          bcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // Double-buffered data: loads park in pending, commit only at frame end;
  // a load in the terminal cycle bypasses pending and commits directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_blink <= '0;
      pend_valid <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      act_blink  <= '0;
    end else if (frame_end) begin
      if (bus.load) begin
        act_value <= bus.value;
        act_dp    <= bus.dp;
        act_en    <= bus.digit_en;
        act_blink <= bus.blink;
      end else if (pend_valid) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_en    <= pend_en;
        act_blink <= pend_blink;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_value <= bus.value;
      pend_dp    <= bus.dp;
      pend_en    <= bus.digit_en;
      pend_blink <= bus.blink;
      pend_valid <= 1'b1;
    end
  end

  // Registered display drive and pulses, one cycle behind the scan state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.an         <= 4'hF;
      bus.seg        <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.frame_tick <= 1'b0;
      bus.upd_ack    <= 1'b0;
    end else begin
      bus.frame_tick <= frame_end;
      bus.upd_ack    <= frame_end && (bus.load || pend_valid);
      if (blank_now) begin
        bus.an   <= 4'hF;
        bus.seg  <= 7'h7F;
        bus.dp_n <= 1'b1;
      end else begin
        bus.an   <= ~(4'b0001 << idx);
        bus.seg  <= seg_dec;
        bus.dp_n <= ~act_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_output_interface.sv
// Directed bench for output_interface with a 4-clock slot, 1-clock guard
// and 2-frame blink half-period (16-clock frames).
module tb_output_interface;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   nticks;
  int   onehot_bad;
  int   cyc;
  logic all_blank;

  output_interface_if bus ();

  output_interface #(
    .SCAN_DIV     (4),
    .GUARD        (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame ticks seen since reset; read at a tick sample it excludes that tick.
  always @(posedge clk or negedge reset) begin
    if (!reset) nticks <= 0;
    else if (bus.frame_tick) nticks <= nticks + 1;
  end

  always @(negedge clk) begin
    if (reset && ($countones(~bus.an) > 1)) onehot_bad = onehot_bad + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    while (cycles < 64) begin
      @(negedge clk);
      cycles = cycles + 1;
      if (bus.frame_tick === 1'b1) break;
    end
    if (bus.frame_tick !== 1'b1) chk("tick_timeout", 16'd0, 16'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] en, input logic [3:0] bl);
    bus.load = 1'b1; bus.value = v; bus.dp = d; bus.digit_en = en; bus.blink = bl;
    step(1);
    bus.load = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; onehot_bad = 0;
    bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.digit_en = '0; bus.blink = '0;
    reset = 1'b0;

    // Reset state.
    step(2);
    chk("rst_an", 16'(bus.an), 16'hF);
    chk("rst_seg", 16'(bus.seg), 16'h7F);
    chk("rst_dp_n", 16'(bus.dp_n), 16'h1);
    chk("rst_tick", 16'(bus.frame_tick), 16'h0);
    chk("rst_ack", 16'(bus.upd_ack), 16'h0);
    reset = 1'b1;

    // No load: blank for 40 clocks, frame period 16.
    all_blank = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.an !== 4'hF || bus.upd_ack !== 1'b0) all_blank = 1'b0;
    end
    chk("idle_blank", 16'(all_blank), 16'h1);
    wait_tick(cyc);
    wait_tick(cyc);
    chk("tick_period", 16'(cyc), 16'd16);

    // First commit and full slot walk.
    step(1);
    do_load(16'h8F10, 4'b0010, 4'hF, 4'h0);
    wait_tick(cyc);
    chk("commit_ack", 16'(bus.upd_ack), 16'h1);
    step(1);
    chk("guard_an", 16'(bus.an), 16'hF);
    step(1);
    chk("d0_an", 16'(bus.an), 16'hE);
    chk("d0_seg", 16'(bus.seg), 16'h40);
    chk("d0_dp_n", 16'(bus.dp_n), 16'h1);
    step(4);
    chk("d1_an", 16'(bus.an), 16'hD);
    chk("d1_seg", 16'(bus.seg), 16'h79);
    chk("d1_dp_n", 16'(bus.dp_n), 16'h0);
    step(4);
    chk("d2_an", 16'(bus.an), 16'hB);
    chk("d2_seg", 16'(bus.seg), 16'h0E);
    step(4);
    chk("d3_an", 16'(bus.an), 16'h7);
    chk("d3_seg", 16'(bus.seg), 16'h00);
    wait_tick(cyc);
    chk("no_commit_ack", 16'(bus.upd_ack), 16'h0);

    // Two loads in one frame: last wins, one ack.
    step(1);
    do_load(16'h1111, 4'h0, 4'hF, 4'h0);
    step(2);
    do_load(16'h2222, 4'h0, 4'hF, 4'h0);
    wait_tick(cyc);
    chk("double_ack", 16'(bus.upd_ack), 16'h1);
    step(2);
    chk("double_seg", 16'(bus.seg), 16'h24);
    wait_tick(cyc);
    chk("double_single_ack", 16'(bus.upd_ack), 16'h0);

    // Load in the terminal cycle commits straight away.
    step(15);
    bus.load = 1'b1; bus.value = 16'h3333; bus.dp = 4'h0; bus.digit_en = 4'hF; bus.blink = 4'h0;
    step(1);
    bus.load = 1'b0;
    chk("tc_tick", 16'(bus.frame_tick), 16'h1);
    chk("tc_ack", 16'(bus.upd_ack), 16'h1);
    step(2);
    chk("tc_seg", 16'(bus.seg), 16'h30);

    // Blink digit 0 only.
    wait_tick(cyc);
    step(1);
    do_load(16'h3333, 4'h0, 4'hF, 4'b0001);
    wait_tick(cyc);
    chk("blink_ack", 16'(bus.upd_ack), 16'h1);
    for (int f = 0; f < 8; f++) begin
      automatic int m = nticks + 1;
      automatic logic phase = ((m / 2) % 2) == 1;
      step(3);
      chk("blink_d0_an", 16'(bus.an), phase ? 16'hF : 16'hE);
      step(4);
      chk("blink_d1_an", 16'(bus.an), 16'hD);
      step(9);
      chk("blink_tick", 16'(bus.frame_tick), 16'h1);
    end
    chk("onehot_an", 16'(onehot_bad), 16'h0);

    // Reset mid-frame discards pending data.
    step(1);
    do_load(16'h4444, 4'hF, 4'hF, 4'h0);
    step(3);
    #2 reset = 1'b0;
    #1;
    chk("midrst_an", 16'(bus.an), 16'hF);
    chk("midrst_seg", 16'(bus.seg), 16'h7F);
    chk("midrst_dp_n", 16'(bus.dp_n), 16'h1);
    step(1);
    reset = 1'b1;
    wait_tick(cyc);
    chk("midrst_ack", 16'(bus.upd_ack), 16'h0);
    all_blank = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (bus.an !== 4'hF || bus.upd_ack !== 1'b0) all_blank = 1'b0;
    end
    chk("midrst_blank", 16'(all_blank), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_interface.md
OUTPUT_INTERFACE -- requirements
Module: output_interface

Interface
REQ-001 Parameters SHALL be:
- SCAN_DIV, default 100000, clocks per digit slot
- GUARD, default 8, blanking clocks at the start of each slot (GUARD < SCAN_DIV)
- BLINK_FRAMES, default 125, frames per blink half-period
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load  in  1  capture strobe for value/dp/digit_en/blink
- value  in  16  four hex digits; digit i = value[4i+3:4i]
- dp  in  4  decimal point per digit, 1 = lit
- digit_en  in  4  1 = digit displayed
- blink  in  4  1 = digit blinks
- an  out  4  digit anodes, active-low
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
- dp_n  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse at end of a full 4-digit scan
- upd_ack  out  1  one-cycle pulse when loaded data becomes active
REQ-003 One clock domain only; reset is asynchronous and active-low.

Function
REQ-004 Divider SHALL count 0..SCAN_DIV-1 and wrap; the terminal count is SCAN_DIV-1.
REQ-005 Digit index (2 bits) SHALL increment at each divider terminal count, wrapping 3->0.
REQ-006 frame_tick SHALL pulse for exactly one cycle, the cycle after the terminal count with index=3.
REQ-007 When load=1, inputs SHALL be captured into pending registers and pending_valid set.
- If a later load arrives before commit, it overwrites the pending data (last wins).
REQ-008 Commit SHALL occur at a frame boundary (terminal count with index=3):
- If pending_valid, pending data goes to active registers and pending_valid clears.
- If load=1 in the same cycle, the inputs of that cycle go directly to the active registers.
REQ-009 upd_ack SHALL pulse for one cycle, coincident with frame_tick, on each commit; with no commit it stays 0.
REQ-010 Blink counter SHALL count frames 0..BLINK_FRAMES-1 and toggle blink_phase on wrap.
REQ-011 Current digit i SHALL be blanked (an[i]=1, seg=7'h7F, dp_n=1) when any of these holds:
- active digit_en[i]=0
- active blink[i]=1 and blink_phase=1
- divider < GUARD
REQ-012 Otherwise:
- an = ~(1<<i)
- seg = active-low hex decode of nibble i
- dp_n = ~dp[i]
REQ-013 Hex decode SHALL use the standard pattern (a-g lit), 0-F, with lowercase b and d:
- 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E
REQ-014 an, seg, dp_n, frame_tick and upd_ack SHALL be registered, one-cycle latency from the internal divider/index state.
REQ-015 At most one an bit SHALL be 0 in any cycle.

Reset
REQ-016 While reset=0, the following SHALL be cleared, asynchronously:
- divider, index, blink counter, blink_phase, pending_valid
- all active and pending registers
REQ-017 Outputs during and after reset SHALL be: an=4'hF, seg=7'h7F, dp_n=1, frame_tick=0, upd_ack=0.
REQ-018 After reset release, the display SHALL stay blank until the first commit.
REQ-019 Reset mid-frame SHALL discard pending data; no upd_ack for it.

Verification (SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2)
REQ-020 Reset -> an=F, seg=7F, dp_n=1; release, 40 clocks, no load -> an stays F; frame_tick period 16 clocks.
REQ-021 load value=16'h8F10, digit_en=F, dp=4'b0010 -> after next frame_tick, upd_ack=1 with it. Then:
- digit 0: an=E, seg=40
- digit 1: an=D, seg=79, dp_n=0
- digit 2: seg=0E
- digit 3: seg=00
- an=F during the first slot clock
REQ-022 Two loads (16'h1111 then 16'h2222) within one frame -> single upd_ack; display shows 2222.
- load in the terminal cycle -> that value active in the next frame.
REQ-023 blink=4'b0001, all enabled -> digit 0 lit for 2 frames, blank for 2 frames, repeating; other digits always lit.
REQ-024 Reset asserted mid-frame with pending load -> outputs blank immediately; after release, no upd_ack and no digit lit.
